dma_register_programmer: RTL and testbench
==========================================

Name: dma_register_programmer

Overview:
- CPU-side bus initiator that programs and reads back the 8237-style DMA controller register file.
- Accepts register requests over a valid/ready command port.
- Generates the timed CS_N/IOR_N/IOW_N/A3..A0/DB slave-bus cycles that the DMA register decoder responds to.
- Splits 16-bit address and word-count accesses into flip-flop-clear, low-byte and high-byte accesses.
- Returns read data or abort status on a one-cycle response strobe.

Parameters:
- SETUP_CYCLES, 1, cycles CS_N/address are valid before the strobe asserts (range 1..15)
- STROBE_CYCLES, 2, cycles IOR_N or IOW_N is held low (range 1..15)
- HOLD_CYCLES, 1, cycles CS_N/address/data are held after the strobe deasserts (range 1..15)

Ports:
- CLK  input  1  system clock, all state on rising edge
- RESET_N  input  1  asynchronous active-low reset
- cmdValid  input  1  command request
- cmdReady  output  1  command accepted on edge when cmdValid && cmdReady
- cmdWrite  input  1  1 = register write, 0 = register read
- cmdAddr  input  4  register code {A3,A2,A1,A0}
- cmdWide  input  1  16-bit access (honoured only when cmdAddr[3]=0)
- cmdData  input  16  write data; bits [7:0] only for narrow writes
- rspValid  output  1  one-cycle completion pulse
- rspData  output  16  read data; 0 for writes and aborts
- rspErr  output  1  valid with rspValid: transaction aborted by HLDA
- HLDA  input  1  DMA owns the system bus
- CS_N  output  1  chip select to DMA
- IOR_N  output  1  register read strobe
- IOW_N  output  1  register write strobe
- ADDR  output  4  {A3,A2,A1,A0}
- DB_OUT  output  8  data driven to the DMA on writes
- DB_OE  output  1  DB_OUT drive enable
- DB_IN  input  8  data returned by the DMA on reads

Behaviour:
- Reset (asynchronous, immediate):
  - CS_N=IOR_N=IOW_N=1, ADDR=0, DB_OUT=0, DB_OE=0.
  - cmdReady=0, rspValid=0, rspData=0, rspErr=0; FSM goes to IDLE.
  - Reset asserted mid-access deasserts all strobes in the same cycle; no response is produced.
- IDLE:
  - cmdReady = !HLDA.
  - On accept, latch all cmd fields and set cmdReady=0 from the next cycle.
  - Build the access list:
    - Narrow (cmdWide=0 or cmdAddr[3]=1): one access at cmdAddr.
    - Wide: three accesses in order: write 8'h00 to 4'hC (clear byte-pointer FF), then low byte, then high byte, both at cmdAddr with cmdWrite's direction.
- Per-access phases:
  - SETUP (SETUP_CYCLES cycles): CS_N=0, ADDR valid, strobes high. DB_OE=1 and DB_OUT valid for writes.
  - STROBE (STROBE_CYCLES cycles): IOW_N=0 for a write, or IOR_N=0 for a read. Never both low.
  - HOLD (HOLD_CYCLES cycles): strobes high, CS_N/ADDR/DB held.
  - GAP (1 cycle, only between accesses of a wide command): CS_N=1, DB_OE=0, ADDR unchanged.
- Read capture: DB_IN is sampled on the clock edge ending the last STROBE cycle. Low access goes to rspData[7:0], high access to rspData[15:8]. Narrow reads zero-extend.
- Completion and latency:
  - After the final HOLD, FSM enters RESP for one cycle: rspValid=1, rspErr=0, CS_N=1, DB_OE=0.
  - Next cycle returns to IDLE.
  - Let P = S+T+H. Accept edge at cycle 0; bus activity occupies cycles 1..P (narrow) or 1..3P+2 (wide); rspValid follows in the next cycle.
  - Defaults: narrow rspValid at cycle 5, wide at cycle 15.
- HLDA abort:
  - HLDA=1 seen in any non-IDLE, non-RESP state (sampled each edge) aborts the command.
  - Next cycle: CS_N=IOR_N=IOW_N=1, DB_OE=0, FSM enters RESP with rspErr=1 and rspData=0.
  - Accesses already completed are not retried.
- Back-to-back: earliest next accept is the IDLE cycle after RESP, giving at least one CS_N=1 cycle between commands.
- Phase counters are 4 bits; parameter value 0 is illegal (elaboration assertion).

Test Plan:
- Narrow write: cmdWrite=1, cmdAddr=4'h8, cmdData=16'h0040, HLDA=0 -> CS_N low cycles 1-4; IOW_N low cycles 2-3; ADDR=8; DB_OUT=8'h40 with DB_OE=1; IOR_N stays 1; rspValid at cycle 5, rspErr=0.
- Wide write: cmdAddr=4'h2, cmdData=16'h1234 -> three IOW_N pulses at ADDR C/2/2 with DB_OUT 00/34/12; CS_N high at cycles 5 and 10; rspValid at cycle 15.
- Wide read: cmdWrite=0, cmdAddr=4'h5; DB_IN=8'hCD during the first read strobe, 8'hAB during the second -> FF-clear write to addr C, two IOR_N pulses at addr 5, DB_OE=0 during reads; rspData=16'hABCD.
- Wide ignored for control registers: cmdAddr=4'hB, cmdWide=1 -> single access only; rspValid at cycle 5.
- HLDA: HLDA=1 in IDLE -> cmdReady=0, no bus activity. HLDA rising during the second access of a wide write -> strobes high next cycle, then rspValid=1, rspErr=1, rspData=0, no third access.
- Reset mid-STROBE of a read -> IOR_N and CS_N go high asynchronously, no rspValid; after release cmdReady=1 and a new narrow read completes normally.

Source files
------------

// File: rtl/dma_register_programmer.sv
// Bus initiator that turns register requests into timed 8237-style CS_N/IOR_N/IOW_N cycles.
// Wide (16-bit) requests become a byte-pointer clear followed by low and high byte accesses.
module dma_register_programmer #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdWrite,
  input  logic [3:0]  cmdAddr,
  input  logic        cmdWide,
  input  logic [15:0] cmdData,
  output logic        rspValid,
  output logic [15:0] rspData,
  output logic        rspErr,
  input  logic        HLDA,
  output logic        CS_N,
  output logic        IOR_N,
  output logic        IOW_N,
  output logic [3:0]  ADDR,
  output logic [7:0]  DB_OUT,
  output logic        DB_OE,
  input  logic [7:0]  DB_IN
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || STROBE_CYCLES < 1 || STROBE_CYCLES > 15 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_param
    $error("dma_register_programmer: phase cycle parameters must be in 1..15");
  end

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

  // Access index: 0 = byte-pointer clear, 1 = low byte, 2 = high byte (narrow starts at 1).
  function automatic logic acc_wr(input logic [1:0] acc, input logic wr);
    return (acc == 2'd0) ? 1'b1 : wr;
  endfunction

  function automatic logic [3:0] acc_addr(input logic [1:0] acc, input logic [3:0] addr);
    return (acc == 2'd0) ? 4'hC : addr;
  endfunction

  function automatic logic [7:0] acc_data(input logic [1:0] acc, input logic [15:0] data);
    case (acc)
      2'd1:    return data[7:0];
      2'd2:    return data[15:8];
      default: return 8'h00;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  acc_q, acc_d;
  logic        wide_q, wide_d;
  logic        wr_q, wr_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [3:0]  bus_addr_q, bus_addr_d;
  logic [7:0]  bus_dout_q, bus_dout_d;

  logic cur_wr, last_acc, in_bus, in_access, wide_eff;
  logic [1:0] acc_start;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    wide_d     = wide_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    bus_addr_d = bus_addr_q;
    bus_dout_d = bus_dout_q;

    cur_wr    = acc_wr(acc_q, wr_q);
    last_acc  = !wide_q || (acc_q == 2'd2);
    in_access = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    in_bus    = in_access || (state_q == ST_GAP);
    cmdReady  = RESET_N && (state_q == ST_IDLE) && !HLDA;
    wide_eff  = cmdWide && !cmdAddr[3];
    acc_start = wide_eff ? 2'd0 : 2'd1;

    if (in_bus && HLDA) begin
      state_d = ST_RESP;
      err_d   = 1'b1;
      rdata_d = 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmdValid && cmdReady) begin
            wr_d       = cmdWrite;
            addr_d     = cmdAddr;
            data_d     = cmdData;
            wide_d     = wide_eff;
            acc_d      = acc_start;
            rdata_d    = 16'h0000;
            err_d      = 1'b0;
            cnt_d      = 4'd0;
            bus_addr_d = acc_addr(acc_start, cmdAddr);
            bus_dout_d = acc_data(acc_start, cmdData);
            state_d    = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_d   = 4'd0;
            state_d = ST_STROBE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            cnt_d   = 4'd0;
            state_d = ST_HOLD;
            if (!cur_wr) begin
              if (acc_q == 2'd2) rdata_d[15:8] = DB_IN;
              else               rdata_d[7:0]  = DB_IN;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = 4'd0;
            if (last_acc) begin
              state_d = ST_RESP;
            end else begin
              state_d = ST_GAP;
              acc_d   = acc_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_GAP: begin
          state_d    = ST_SETUP;
          bus_addr_d = acc_addr(acc_q, addr_q);
          bus_dout_d = acc_data(acc_q, data_q);
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      acc_q      <= 2'd0;
      wide_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 4'd0;
      data_q     <= 16'h0000;
      rdata_q    <= 16'h0000;
      err_q      <= 1'b0;
      bus_addr_q <= 4'd0;
      bus_dout_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      wide_q     <= wide_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      bus_addr_q <= bus_addr_d;
      bus_dout_q <= bus_dout_d;
    end
  end

  assign CS_N     = !in_access;
  assign IOW_N    = !((state_q == ST_STROBE) && cur_wr);
  assign IOR_N    = !((state_q == ST_STROBE) && !cur_wr);
  assign DB_OE    = in_access && cur_wr;
  assign DB_OUT   = bus_dout_q;
  assign ADDR     = bus_addr_q;
  assign rspValid = (state_q == ST_RESP);
  assign rspErr   = (state_q == ST_RESP) && err_q;
  assign rspData  = ((state_q == ST_RESP) && !err_q) ? rdata_q : 16'h0000;

endmodule

// File: tb/tb_dma_register_programmer.sv
// Bench for dma_register_programmer: a per-cycle expected bus trace is built from each accepted
// command and compared against the DUT, alongside directed literal checks.
module tb_dma_register_programmer;
  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 1;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic        cmdWrite = 1'b0;
  logic [3:0]  cmdAddr = 4'h0;
  logic        cmdWide = 1'b0;
  logic [15:0] cmdData = 16'h0000;
  logic        rspValid;
  logic [15:0] rspData;
  logic        rspErr;
  logic        HLDA = 1'b0;
  logic        CS_N, IOR_N, IOW_N, DB_OE;
  logic [3:0]  ADDR;
  logic [7:0]  DB_OUT;
  logic [7:0]  DB_IN = 8'h00;

  dma_register_programmer #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdWrite(cmdWrite), .cmdAddr(cmdAddr), .cmdWide(cmdWide), .cmdData(cmdData),
    .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr), .HLDA(HLDA),
    .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .ADDR(ADDR), .DB_OUT(DB_OUT),
    .DB_OE(DB_OE), .DB_IN(DB_IN)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int cs_falls = 0;
  int rd_pulses = 0;
  bit dir_mode = 0;
  bit chk_en = 0;

  always @(negedge CS_N) cs_falls++;
  always @(posedge IOR_N) rd_pulses++;

  always @(posedge CLK) begin
    #1;
    DB_IN = dir_mode ? ((rd_pulses == 0) ? 8'hCD : 8'hAB) : 8'($urandom);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected trace: one record per bus cycle after an accept, ending in a response record.
  typedef struct {
    logic       cs_n, ior_n, iow_n, oe;
    logic [3:0] addr;
    logic [7:0] dout;
    logic       cap, hi, rsp, err;
  } rec_t;

  rec_t        q[$];
  logic [15:0] m_rd;
  logic        m_wr;

  task automatic push_access(input logic w, input logic [3:0] a, input logic [7:0] d,
                             input logic hi, input logic gap);
    rec_t r;
    r = '{cs_n: 1'b0, ior_n: 1'b1, iow_n: 1'b1, oe: w, addr: a, dout: d,
          cap: 1'b0, hi: hi, rsp: 1'b0, err: 1'b0};
    for (int i = 0; i < S; i++) q.push_back(r);
    for (int i = 0; i < T; i++) begin
      r.ior_n = w;
      r.iow_n = !w;
      r.cap   = !w && (i == T - 1);
      q.push_back(r);
    end
    r.ior_n = 1'b1; r.iow_n = 1'b1; r.cap = 1'b0;
    for (int i = 0; i < H; i++) q.push_back(r);
    if (gap) begin
      r.cs_n = 1'b1; r.oe = 1'b0;
      q.push_back(r);
    end
  endtask

  task automatic push_rsp(input logic err);
    rec_t r;
    r = '{cs_n: 1'b1, ior_n: 1'b1, iow_n: 1'b1, oe: 1'b0, addr: 4'h0, dout: 8'h00,
          cap: 1'b0, hi: 1'b0, rsp: 1'b1, err: err};
    q.push_back(r);
  endtask

  task automatic build(input logic w, input logic [3:0] a, input logic wide, input logic [15:0] d);
    m_rd = 16'h0000;
    m_wr = w;
    if (wide && !a[3]) begin
      push_access(1'b1, 4'hC, 8'h00, 1'b0, 1'b1);
      push_access(w, a, d[7:0], 1'b0, 1'b1);
      push_access(w, a, d[15:8], 1'b1, 1'b0);
    end else begin
      push_access(w, a, d[7:0], 1'b0, 1'b0);
    end
    push_rsp(1'b0);
  endtask

  always @(negedge CLK) begin
    rec_t r;
    if (!RESET_N || !chk_en) begin
      q.delete();
    end else if (q.size() == 0) begin
      chk("idle_bus", {26'd0, CS_N, IOR_N, IOW_N, DB_OE, rspValid, cmdReady},
          {26'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, !HLDA});
      if (cmdValid && !HLDA) build(cmdWrite, cmdAddr, cmdWide, cmdData);
    end else begin
      r = q.pop_front();
      if (r.rsp) begin
        chk("rsp_ctl", {25'd0, rspValid, rspErr, CS_N, IOR_N, IOW_N, DB_OE, cmdReady},
            {25'd0, 1'b1, r.err, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        chk("rsp_data", {16'd0, rspData}, {16'd0, (r.err || m_wr) ? 16'h0000 : m_rd});
      end else begin
        chk("bus", {21'd0, CS_N, IOR_N, IOW_N, DB_OE, ADDR, cmdReady, rspValid},
            {21'd0, r.cs_n, r.ior_n, r.iow_n, r.oe, r.addr, 1'b0, 1'b0});
        if (r.oe) chk("db_out", {24'd0, DB_OUT}, {24'd0, r.dout});
        if (HLDA) begin
          q.delete();
          push_rsp(1'b1);
        end else if (r.cap) begin
          if (r.hi) m_rd[15:8] = DB_IN;
          else      m_rd[7:0]  = DB_IN;
        end
      end
    end
  end

  task automatic do_cmd(input logic w, input logic [3:0] a, input logic wide,
                        input logic [15:0] d, input int abort_at,
                        output int lat, output logic [15:0] rd, output logic er);
    bit ok;
    lat = -1; rd = 16'hxxxx; er = 1'bx;
    cmdWrite = w; cmdAddr = a; cmdWide = wide; cmdData = d; cmdValid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (cmdReady) begin ok = 1; break; end
    end
    @(posedge CLK); #1;
    cmdValid = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == abort_at) HLDA = 1'b1;
      @(negedge CLK);
      if (rspValid) begin
        lat = cyc; rd = rspData; er = rspErr;
        break;
      end
      @(posedge CLK); #1;
    end
    if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
    else begin
      @(posedge CLK); #1;
    end
    HLDA = 1'b0;
  endtask

  initial begin
    int          lat, c0;
    logic [15:0] rd;
    logic        er;
    bit          seen;

    #2;
    chk("reset_outs", {16'd0, CS_N, IOR_N, IOW_N, DB_OE, cmdReady, rspValid, rspErr, ADDR, DB_OUT == 8'h00},
        {16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1});
    chk("reset_rspdata", {16'd0, rspData}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    chk_en = 1;
    @(posedge CLK); #1;

    c0 = cs_falls;
    do_cmd(1'b1, 4'h8, 1'b0, 16'h0040, 0, lat, rd, er);
    chk("narrow_wr_lat", lat, 5);
    chk("narrow_wr_err", {31'd0, er}, 32'd0);
    chk("narrow_wr_cs", cs_falls - c0, 1);

    c0 = cs_falls;
    do_cmd(1'b1, 4'h2, 1'b1, 16'h1234, 0, lat, rd, er);
    chk("wide_wr_lat", lat, 15);
    chk("wide_wr_cs", cs_falls - c0, 3);

    dir_mode = 1; rd_pulses = 0;
    do_cmd(1'b0, 4'h5, 1'b1, 16'h0000, 0, lat, rd, er);
    dir_mode = 0;
    chk("wide_rd_lat", lat, 15);
    chk("wide_rd_data", {16'd0, rd}, 32'h0000ABCD);

    c0 = cs_falls;
    do_cmd(1'b1, 4'hB, 1'b1, 16'h5A5A, 0, lat, rd, er);
    chk("ctrl_wide_lat", lat, 5);
    chk("ctrl_wide_cs", cs_falls - c0, 1);

    c0 = cs_falls;
    HLDA = 1'b1; cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 4'h3; cmdWide = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hlda_idle_ready", {31'd0, cmdReady}, 32'd0);
    end
    @(posedge CLK); #1;
    cmdValid = 1'b0; HLDA = 1'b0;
    chk("hlda_idle_cs", cs_falls - c0, 0);
    @(posedge CLK); #1;

    c0 = cs_falls;
    do_cmd(1'b1, 4'h2, 1'b1, 16'h1234, 7, lat, rd, er);
    chk("abort_lat", lat, 8);
    chk("abort_err", {31'd0, er}, 32'd1);
    chk("abort_data", {16'd0, rd}, 32'd0);
    chk("abort_cs", cs_falls - c0, 2);

    for (int n = 0; n < 40; n++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
      do_cmd(1'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), ab, lat, rd, er);
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end

    chk_en = 0;
    cmdWrite = 1'b0; cmdAddr = 4'h6; cmdWide = 1'b0; cmdValid = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    cmdValid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (!IOR_N) begin seen = 1; break; end
    end
    chk("rst_reach_strobe", {31'd0, seen}, 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_async_outs", {28'd0, IOR_N, CS_N, cmdReady, DB_OE}, {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rst_no_rsp", {31'd0, rspValid}, 32'd0);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    chk_en = 1;
    @(negedge CLK);
    chk("post_rst_ready", {31'd0, cmdReady}, 32'd1);
    @(posedge CLK); #1;
    do_cmd(1'b0, 4'h6, 1'b0, 16'h0000, 0, lat, rd, er);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_err", {31'd0, er}, 32'd0);
    chk("post_rst_hi_zero", {24'd0, rd[15:8]}, 32'd0);

    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
